// File: rtl/clk_en_sequencer.sv
// ---------------------------------------------------------------------------
// clk_en_sequencer
//
// Staggers a bank of clock-enable lines on and off so downstream clock
// generators do not all switch at once. A start request latches the spacing
// and run length, turns the enables on one at a time in ascending order,
// holds them all on for the run length (or until stop_i when the run length
// is zero), then turns them off one at a time in descending order.
//
// Parameters
//   NUM_CH     number of enable channels (1..16)
//   CNT_W      width of the spacing / run-length counters
//
// Ports
//   clk_i      system clock, everything updates on the rising edge
//   rst_i      synchronous active-high reset, drops all enables immediately
//   start_i    begin a sequence (only honoured while idle and stop_i is low)
//   stop_i     end a sequence early (ignored while idle or ramping down)
//   step_i     spacing between channel events, step_i+1 cycles
//   run_len_i  cycles all channels stay enabled, 0 means until stop_i
//   clk_en_o   registered enables, bit k drives channel k
//   busy_o     registered, high while a sequence is in progress
//   done_o     registered one-cycle pulse when a sequence finishes
// ---------------------------------------------------------------------------
module clk_en_sequencer #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [CNT_W-1:0]  step_i,
    input  logic [CNT_W-1:0]  run_len_i,
    output logic [NUM_CH-1:0] clk_en_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  step_q;
    logic [CNT_W-1:0]  run_q;
    logic [CNT_W-1:0]  cnt;

    logic [NUM_CH-1:0] en_up;
    logic [NUM_CH-1:0] en_dn;
    logic              do_clear;

    // The enables always form a thermometer code anchored at bit 0, so
    // turning on the next channel is a shift-in of a one and turning off the
    // highest channel is a right shift. This keeps every step a single-bit
    // change by construction.
    assign en_up = (clk_en_o << 1) | NUM_CH'(1);
    assign en_dn = clk_en_o >> 1;

    // A "clear" drops the highest set enable. It happens when stop_i lands in
    // RAMP_UP or RUN, when a finite run expires, and on each ramp-down step.
    // Folding all of these into one flag means a stop that coincides with a
    // scheduled event is acted on exactly once.
    always_comb begin
        do_clear = 1'b0;
        case (state)
            RAMP_UP:   do_clear = stop_i;
            RUN:       do_clear = stop_i || ((run_q != '0) && (cnt == '0));
            RAMP_DOWN: do_clear = (cnt == '0);
            default:   do_clear = 1'b0;
        endcase
    end

    // Main sequencer. cnt is a down-counter that is reloaded rather than
    // wrapped: loading step_q and firing at zero gives step_q+1 cycles of
    // spacing, which reaches 2^CNT_W cycles without needing an extra bit.
    // In RUN the same counter is loaded with run_q-1 at the edge that sets
    // the last enable so the first clear lands exactly run_q cycles later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            clk_en_o <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            cnt      <= '0;
            step_q   <= '0;
            run_q    <= '0;
        end else begin
            done_o <= 1'b0;
            if (do_clear) begin
                clk_en_o <= en_dn;
                if (en_dn == '0) begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                    cnt    <= '0;
                end else begin
                    state <= RAMP_DOWN;
                    cnt   <= step_q;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i && !stop_i) begin
                            state  <= RAMP_UP;
                            step_q <= step_i;
                            run_q  <= run_len_i;
                            cnt    <= step_i;
                            busy_o <= 1'b1;
                        end
                    end
                    RAMP_UP: begin
                        if (cnt == '0) begin
                            clk_en_o <= en_up;
                            if (en_up[NUM_CH-1]) begin
                                state <= RUN;
                                cnt   <= (run_q != '0) ? (run_q - CNT_W'(1)) : '0;
                            end else begin
                                cnt <= step_q;
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    RUN: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    RAMP_DOWN: begin
                        cnt <= cnt - CNT_W'(1);
                    end
                    default: begin
                        state    <= IDLE;
                        clk_en_o <= '0;
                        busy_o   <= 1'b0;
                        cnt      <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_en_sequencer.sv
// ---------------------------------------------------------------------------
// tb_clk_en_sequencer
//
// Self-checking bench for clk_en_sequencer. Expected enable/busy/done values
// for every cycle of a sequence are derived from the event times of the
// sequence (set time, clear time and finish time of each channel), computed
// with plain arithmetic from the step, run length, stop and reset times.
// ---------------------------------------------------------------------------
module tb_clk_en_sequencer;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic              stop;
    logic [CNT_W-1:0]  step_in;
    logic [CNT_W-1:0]  run_in;
    logic [NUM_CH-1:0] clk_en;
    logic              busy;
    logic              done;

    int vectors;
    int miscompares;

    clk_en_sequencer #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .stop_i    (stop),
        .step_i    (step_in),
        .run_len_i (run_in),
        .clk_en_o  (clk_en),
        .busy_o    (busy),
        .done_o    (done)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Runs one sequence whose start request is already being driven and
    // checks every cycle against event times derived from the parameters.
    // Time t is the number of edges after the accepting edge T0; samples are
    // taken 1 unit after each edge. stop_t/extra_start/rst_t are edge
    // offsets at which stop_i/start_i/rst_i are high (-1 for never). With
    // noise set, the config inputs are scrambled every cycle.
    task automatic run_and_check_sequence(input int step, input int run,
                                          input int stop_t, input bit noise,
                                          input int extra_start, input int rst_t,
                                          input string name);
        int s, tl, m, c, d;
        int set_t[NUM_CH];
        int clr_t[NUM_CH];
        logic [NUM_CH-1:0] exp_en;
        logic exp_busy, exp_done;

        s  = step + 1;
        tl = NUM_CH * s;
        if (stop_t > 0 && stop_t <= tl) begin
            m = (stop_t - 1) / s;
            c = stop_t;
        end else if (stop_t > tl && (run == 0 || stop_t <= tl + run)) begin
            m = NUM_CH;
            c = stop_t;
        end else begin
            m = NUM_CH;
            c = tl + run;
        end
        d = (m == 0) ? c : c + (m - 1) * s;
        for (int k = 0; k < NUM_CH; k++) begin
            set_t[k] = (k + 1) * s;
            clr_t[k] = (k < m) ? c + (m - 1 - k) * s : 0;
        end

        @(posedge clk);
        #1;
        start = 1'b0;
        for (int t = 0; t <= d + 2; t++) begin
            for (int k = 0; k < NUM_CH; k++)
                exp_en[k] = (k < m) && (t >= set_t[k]) && (t < clr_t[k]);
            exp_busy = (t < d);
            exp_done = (t == d);
            if (rst_t > 0 && t == rst_t) begin
                exp_en   = '0;
                exp_busy = 1'b0;
                exp_done = 1'b0;
            end

            vectors++;
            if (clk_en !== exp_en) begin
                miscompares++;
                $display("[TB] FAIL %s clk_en t=%0d: got %b expected %b", name, t, clk_en, exp_en);
            end
            vectors++;
            if (busy !== exp_busy) begin
                miscompares++;
                $display("[TB] FAIL %s busy t=%0d: got %b expected %b", name, t, busy, exp_busy);
            end
            vectors++;
            if (done !== exp_done) begin
                miscompares++;
                $display("[TB] FAIL %s done t=%0d: got %b expected %b", name, t, done, exp_done);
            end

            if (rst_t > 0 && t == rst_t) break;

            stop  = (t + 1 == stop_t);
            start = (t + 1 == extra_start);
            rst   = (t + 1 == rst_t);
            if (noise) begin
                step_in = CNT_W'($urandom);
                run_in  = CNT_W'($urandom);
            end
            @(posedge clk);
            #1;
        end
        stop  = 1'b0;
        start = 1'b0;
    endtask

    // Drives a start request with the given config, then checks the sequence.
    task automatic launch(input int step, input int run, input int stop_t,
                          input bit noise, input int extra_start, input int rst_t,
                          input string name);
        start   = 1'b1;
        stop    = 1'b0;
        step_in = CNT_W'(step);
        run_in  = CNT_W'(run);
        run_and_check_sequence(step, run, stop_t, noise, extra_start, rst_t, name);
    endtask

    // Reset must hold everything low even with start asserted, and start
    // must be taken on the very first edge after reset is released.
    task automatic test_reset();
        rst     = 1'b1;
        start   = 1'b1;
        step_in = CNT_W'(1);
        run_in  = CNT_W'(1);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (clk_en !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset clk_en: got %b expected %b", clk_en, {NUM_CH{1'b0}});
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset busy: got %b expected 0", busy);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset done: got %b expected 0", done);
        end
        rst = 1'b0;
        run_and_check_sequence(1, 1, -1, 1'b0, -1, -1, "start_after_reset");
    endtask

    task automatic test_nominal();
        launch(2, 5, -1, 1'b0, -1, -1, "nominal");
    endtask

    task automatic test_zero_step();
        launch(0, 1, -1, 1'b0, -1, -1, "zero_step");
    endtask

    // Run length zero holds until stop; a start pulse while busy is ignored.
    task automatic test_indefinite_run();
        launch(1, 0, 20, 1'b0, 15, -1, "indefinite_run");
    endtask

    task automatic test_early_stop();
        launch(4, 3, 7, 1'b0, -1, -1, "early_stop_one_bit");
        launch(4, 3, 3, 1'b0, -1, -1, "early_stop_no_bit");
        launch(2, 5, 12, 1'b0, -1, -1, "stop_on_last_set");
        launch(2, 5, 6, 1'b0, -1, -1, "stop_on_step_edge");
    endtask

    // A stop landing on the same edge as run expiry must clear only one bit.
    task automatic test_stop_on_expiry();
        launch(2, 5, 17, 1'b0, -1, -1, "stop_on_expiry");
        launch(2, 5, 20, 1'b0, -1, -1, "stop_in_ramp_down");
    endtask

    task automatic test_mid_run_reset();
        launch(2, 5, -1, 1'b0, -1, 10, "mid_run_reset");
        rst     = 1'b0;
        start   = 1'b1;
        step_in = CNT_W'(3);
        run_in  = CNT_W'(2);
        run_and_check_sequence(3, 2, -1, 1'b0, -1, -1, "restart_after_reset");
    endtask

    task automatic test_config_isolation();
        launch(3, 4, -1, 1'b1, -1, -1, "config_isolation");
    endtask

    // Simultaneous start and stop while idle must leave the block idle.
    task automatic test_start_stop_idle();
        start   = 1'b1;
        stop    = 1'b1;
        step_in = CNT_W'(0);
        run_in  = CNT_W'(1);
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (busy !== 1'b0 || clk_en !== '0 || done !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL start_stop_idle cycle %0d: got busy=%b en=%b done=%b expected busy=0 en=0 done=0",
                         i, busy, clk_en, done);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Largest spacing and run length the counters can hold.
    task automatic test_max_step();
        launch((1 << CNT_W) - 1, (1 << CNT_W) - 1, -1, 1'b0, -1, -1, "max_step");
    endtask

    task automatic test_random();
        int step, run, tl, stop_t;
        for (int i = 0; i < 10; i++) begin
            step = int'($urandom_range(0, 5));
            run  = int'($urandom_range(0, 8));
            tl   = NUM_CH * (step + 1);
            if (run == 0 || $urandom_range(0, 1) == 1)
                stop_t = int'($urandom_range(1, tl + run + NUM_CH * (step + 1)));
            else
                stop_t = -1;
            launch(step, run, stop_t, i[0], -1, -1, "random");
        end
    endtask

    initial begin
        clk         = 1'b0;
        rst         = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        step_in     = '0;
        run_in      = '0;
        vectors     = 0;
        miscompares = 0;

        test_reset();
        test_nominal();
        test_zero_step();
        test_indefinite_run();
        test_early_stop();
        test_stop_on_expiry();
        test_mid_run_reset();
        test_config_isolation();
        test_start_stop_idle();
        test_max_step();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clk_en_sequencer.md
CLK_EN_SEQUENCER -- requirements
Module: clk_en_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4, number of sequenced clock-enable channels (range 1..16).
REQ-002 Parameter CNT_W, default 16, width of step and run-length counters.
REQ-003 clk_i  input  1  system clock; all logic on rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 start_i  input  1  request to start a sequence; sampled each cycle.
REQ-006 stop_i  input  1  request to end a sequence early; sampled each cycle.
REQ-007 step_i  input  CNT_W  inter-channel spacing; spacing is step_i+1 cycles.
REQ-008 run_len_i  input  CNT_W  cycles all channels stay enabled; 0 means until stop_i.
REQ-009 clk_en_o  output  NUM_CH  enables for downstream clock generators, bit k drives channel k.
REQ-010 busy_o  output  1  high while a sequence is in progress.
REQ-011 done_o  output  1  one-cycle pulse when a sequence completes.

Function
REQ-012 FSM states SHALL be IDLE, RAMP_UP, RUN and RAMP_DOWN. All outputs SHALL be registered.
REQ-013 In IDLE, start_i=1 with stop_i=0 SHALL move to RAMP_UP, latch step_i/run_len_i into step_q/run_q, and set busy_o=1 at that edge (edge T0).
REQ-014 Configuration inputs SHALL be ignored while busy_o=1; only step_q/run_q apply.
REQ-015 start_i while busy_o=1 SHALL be ignored; no queuing.
REQ-016 In IDLE, simultaneous start_i and stop_i SHALL be ignored (stop priority); state stays IDLE.
REQ-017 RAMP_UP SHALL set clk_en_o[k] at edge T0+(k+1)*(step_q+1), ascending order, one bit per step. Already-set bits stay set.
REQ-018 RAMP_UP SHALL go to RUN at the edge that sets clk_en_o[NUM_CH-1] (edge TL).
REQ-019 RUN with run_q=N>0 SHALL clear clk_en_o[NUM_CH-1] at edge TL+N and enter RAMP_DOWN.
REQ-020 RUN with run_q=0 SHALL hold all enables until stop_i is sampled.
REQ-021 RAMP_DOWN SHALL clear one bit per step, descending order, spacing step_q+1 cycles after the previous clear.
REQ-022 The edge that clears clk_en_o[0] SHALL return to IDLE, drive busy_o=0 and pulse done_o=1 for exactly one cycle.
REQ-023 stop_i in RUN SHALL clear clk_en_o[NUM_CH-1] at the sampling edge and enter RAMP_DOWN; later bits follow REQ-021.
REQ-024 stop_i in RAMP_UP with at least one bit set SHALL block further enables and clear the highest set bit at the sampling edge, then continue per REQ-021.
REQ-025 stop_i in RAMP_UP with no bit set SHALL go to IDLE at the sampling edge, with busy_o=0 and a done_o pulse.
REQ-026 stop_i in RAMP_DOWN or IDLE SHALL have no effect.
REQ-027 Step and run counters SHALL be CNT_W bits and SHALL never wrap. step_q=2^CNT_W-1 gives a spacing of 2^CNT_W cycles.
REQ-028 If stop_i and a scheduled step event fall on the same edge, stop_i handling SHALL take precedence and SHALL act exactly once.
REQ-029 clk_en_o SHALL change only at its scheduled edges; no glitches or multi-bit changes within one step.

Reset
REQ-030 While rst_i=1 at a rising edge: state=IDLE, clk_en_o=0, busy_o=0, done_o=0, counters=0, step_q=0, run_q=0.
REQ-031 Reset SHALL override all inputs, including mid-sequence. All enables SHALL drop at the reset edge with no ramp-down and no done_o pulse.
REQ-032 start_i SHALL be accepted on the first edge after rst_i deasserts.

Verification
REQ-033 Nominal sequence. NUM_CH=4, step_i=2, run_len_i=5, start at T0. Required: en[0..3] set at T0+3/6/9/12; en[3..0] cleared at T0+17/20/23/26. busy_o falls and done_o pulses at T0+26.
REQ-034 Zero step. step_i=0, run_len_i=1. Required: en bits set at T0+1..T0+4 and cleared at T0+5..T0+8. done_o at T0+8.
REQ-035 Indefinite run. run_len_i=0, step_i=1, stop at T0+20. Required: en[3] cleared at T0+20 and en[0] at T0+26 with done_o. Required: an earlier start pulse at T0+15 has no effect.
REQ-036 Early stop. step_i=4, stop at T0+7 (only en[0] set). Required: en[0] cleared at T0+7, IDLE and done_o at T0+7. Separately, stop at T0+3 gives IDLE with done_o at T0+3 and no bit ever set.
REQ-037 Mid-run reset. rst_i=1 at T0+10 during RAMP_UP. Required: all outputs 0 at T0+10 and no done_o. A new start at the next edge after release is accepted with freshly latched config.
REQ-038 Config isolation. step_i and run_len_i change every cycle while busy_o=1. Required: timing matches the values latched at T0.
